// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
//   Types and constants shared by the EX-stage branch resolution logic.
//   br_op_t     : 3-bit branch operation code
//   state_t     : resolve-stage control state (RUN / FLUSH)
//   PC_STEP     : byte distance to the sequential instruction
//   FLUSH_CNT_W : width of the wrong-path squash counter
//   sat_inc32() : saturating 32-bit increment for the statistics counters
// ---------------------------------------------------------------------------
package branch_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd2,
        BR_BGE  = 3'd3,
        BR_BLTU = 3'd4,
        BR_BGEU = 3'd5,
        BR_JR   = 3'd6,
        BR_NOP  = 3'd7
    } br_op_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int PC_STEP     = 4;
    localparam int FLUSH_CNT_W = 3;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        logic [31:0] res;
        if (val == 32'hFFFF_FFFF) begin
            res = val;
        end else begin
            res = val + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// ---------------------------------------------------------------------------
// branch_compare
//   Combinational operand comparator built on a single WIDTH+1 bit subtract.
//   Ports:
//     a, b  in  WIDTH  operands (rs, rt)
//     eq    out 1      a == b
//     lt_s  out 1      a <  b, two's-complement
//     lt_u  out 1      a <  b, unsigned
// ---------------------------------------------------------------------------
module branch_compare #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             lt_s,
    output logic             lt_u
);

    logic [WIDTH:0] diff_s;
    logic           ovf_s;

    // One subtractor feeds all three flags; the extra MSB is the borrow.
    always_comb begin
        diff_s = {1'b0, a} - {1'b0, b};
        // Signed overflow: operands differ in sign and the result sign
        // differs from a's sign, so the raw sign bit is inverted.
        ovf_s  = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ diff_s[WIDTH-1]);
        lt_s   = diff_s[WIDTH-1] ^ ovf_s;
        lt_u   = diff_s[WIDTH];
        eq     = (diff_s[WIDTH-1:0] == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/branch_resolve_stage.sv
// ---------------------------------------------------------------------------
// branch_resolve_stage
//   EX-stage branch resolution: decides taken/not-taken, computes the next
//   PC, registers the result behind a valid/ready handshake, pulses a PC
//   redirect on a taken branch and squashes FLUSH_CYCLES younger beats.
//
//   Parameters:
//     WIDTH         operand/address width (>= 18)
//     FLUSH_CYCLES  wrong-path slots squashed after a taken branch (1..7)
//   Ports:
//     clk, reset_n        clock, synchronous active-low reset
//     in_valid/in_ready   input handshake (op, a, b, pc, imm)
//     out_valid/out_ready output handshake (taken, target)
//     redirect            one-cycle pulse: load target into the PC
//     flush               high while wrong-path beats are being dropped
//     br_count, tk_count  resolved / taken branch counters
//   Build option:
//     BRANCH_STATS_EN     when defined, br_count/tk_count are saturating
//                         counters; otherwise both are tied to zero.
// ---------------------------------------------------------------------------
module branch_resolve_stage
    import branch_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  br_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc,
    input  logic [15:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [WIDTH-1:0] target,
    output logic             redirect,
    output logic             flush,
    output logic [31:0]      br_count,
    output logic [31:0]      tk_count
);

    // Squash length limited to what the counter can hold, and at least one.
    localparam int FLUSH_N = (FLUSH_CYCLES < 1) ? 1 :
                             ((FLUSH_CYCLES > 7) ? 7 : FLUSH_CYCLES);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_N);

    // Control state
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [FLUSH_CNT_W-1:0] cnt_r;
    logic [FLUSH_CNT_W-1:0] cnt_nxt_s;
    logic                   in_ready_s;
    logic                   acc_run_s;

    // Compare / decode / target
    logic                   eq_s;
    logic                   lt_signed_s;
    logic                   lt_unsigned_s;
    logic                   taken_s;
    logic [WIDTH-1:0]       imm_ext_s;
    logic [WIDTH-1:0]       seq_pc_s;
    logic [WIDTH-1:0]       br_pc_s;
    logic [WIDTH-1:0]       target_s;

    // Result register
    logic                   out_valid_r;
    logic                   taken_r;
    logic [WIDTH-1:0]       target_r;
    logic                   redirect_r;
    logic                   flush_r;

    branch_compare #(
        .WIDTH (WIDTH)
    ) u_compare (
        .a    (a),
        .b    (b),
        .eq   (eq_s),
        .lt_s (lt_signed_s),
        .lt_u (lt_unsigned_s)
    );

    // Branch direction decode from the comparator flags.
    always_comb begin
        taken_s = 1'b0;
        case (op)
            BR_BEQ:  taken_s = eq_s;
            BR_BNE:  taken_s = ~eq_s;
            BR_BLT:  taken_s = lt_signed_s;
            BR_BGE:  taken_s = ~lt_signed_s;
            BR_BLTU: taken_s = lt_unsigned_s;
            BR_BGEU: taken_s = ~lt_unsigned_s;
            BR_JR:   taken_s = 1'b1;
            BR_NOP:  taken_s = 1'b0;
            default: taken_s = 1'b0;
        endcase
    end

    // Next-PC selection; all sums wrap modulo 2^WIDTH.
    always_comb begin
        imm_ext_s = {{(WIDTH-16){imm[15]}}, imm};
        seq_pc_s  = pc + WIDTH'(PC_STEP);
        br_pc_s   = seq_pc_s + (imm_ext_s << 2'd2);
        if (op == BR_JR) begin
            target_s = a;
        end else if (taken_s) begin
            target_s = br_pc_s;
        end else begin
            target_s = seq_pc_s;
        end
    end

    // FSM next-state and input handshake.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        in_ready_s  = 1'b0;
        acc_run_s   = 1'b0;
        case (state_r)
            RUN: begin
                in_ready_s = ~out_valid_r | out_ready;
                acc_run_s  = in_valid & in_ready_s;
                if (acc_run_s & taken_s) begin
                    state_nxt_s = FLUSH;
                    cnt_nxt_s   = FLUSH_LOAD;
                end else begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = cnt_r;
                end
            end
            FLUSH: begin
                // Every beat is swallowed here; the counter runs regardless
                // of whether a beat arrived.
                in_ready_s = 1'b1;
                if (cnt_r <= {{(FLUSH_CNT_W-1){1'b0}}, 1'b1}) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = {FLUSH_CNT_W{1'b0}};
                end else begin
                    state_nxt_s = FLUSH;
                    cnt_nxt_s   = cnt_r - {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = {FLUSH_CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state and squash counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= RUN;
            cnt_r   <= {FLUSH_CNT_W{1'b0}};
            flush_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            flush_r <= (state_nxt_s == FLUSH);
        end
    end

    // Result register; a held result is only replaced by a RUN-state accept,
    // so a taken result survives the whole squash window.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            taken_r     <= 1'b0;
            target_r    <= {WIDTH{1'b0}};
            redirect_r  <= 1'b0;
        end else begin
            redirect_r <= acc_run_s & taken_s;
            if (acc_run_s) begin
                out_valid_r <= 1'b1;
                taken_r     <= taken_s;
                target_r    <= target_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign taken     = taken_r;
    assign target    = target_r;
    assign redirect  = redirect_r;
    assign flush     = flush_r;

`ifdef BRANCH_STATS_EN
    br_op_t      op_r;
    logic        out_xfer_s;
    logic [31:0] br_count_r;
    logic [31:0] tk_count_r;

    assign out_xfer_s = out_valid_r & out_ready;

    // Remember the op of the held result so NOPs are excluded from stats.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_r <= BR_NOP;
        end else if (acc_run_s) begin
            op_r <= op;
        end else begin
            op_r <= op_r;
        end
    end

    // Saturating statistics, counted when a result leaves the stage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            br_count_r <= 32'd0;
            tk_count_r <= 32'd0;
        end else if (out_xfer_s && (op_r != BR_NOP)) begin
            br_count_r <= sat_inc32(br_count_r);
            if (taken_r) begin
                tk_count_r <= sat_inc32(tk_count_r);
            end else begin
                tk_count_r <= tk_count_r;
            end
        end else begin
            br_count_r <= br_count_r;
            tk_count_r <= tk_count_r;
        end
    end

    assign br_count = br_count_r;
    assign tk_count = tk_count_r;
`else
    assign br_count = 32'd0;
    assign tk_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_stage.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_stage
//   Directed stimulus with hand-computed expectations pushed into a queue;
//   a negedge monitor pops and compares on every output transfer.
// ---------------------------------------------------------------------------
module tb_branch_resolve_stage;
    import branch_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    br_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic        taken;
    logic [31:0] target;
    logic        redirect;
    logic        flush;
    logic [31:0] br_count;
    logic [31:0] tk_count;

    typedef struct {
        logic        tk;
        logic [31:0] tg;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef BRANCH_STATS_EN
    localparam logic [31:0] EXP_BR = 32'd5;
    localparam logic [31:0] EXP_TK = 32'd2;
`else
    localparam logic [31:0] EXP_BR = 32'd0;
    localparam logic [31:0] EXP_TK = 32'd0;
`endif

    branch_resolve_stage #(
        .WIDTH        (32),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .pc        (pc),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .taken     (taken),
        .target    (target),
        .redirect  (redirect),
        .flush     (flush),
        .br_count  (br_count),
        .tk_count  (tk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare on every output transfer.
    always @(negedge clk) begin
        if (reset_n && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: taken=%0b target=%0h with empty queue", taken, target);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_taken", {63'd0, taken}, {63'd0, e.tk});
                chk("out_target", {32'd0, target}, {32'd0, e.tg});
            end
        end
    end

    // Offer one beat once the stage is in RUN and ready; returns #1 after the accept edge.
    task automatic issue(input br_op_t o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] vpc, input logic [15:0] vimm,
                         input logic push, input logic etk, input logic [31:0] etg);
        int t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!(in_ready === 1'b1 && flush === 1'b0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            chk("issue_timeout", 64'd1, 64'd0);
        end else begin
            op = o; a = va; b = vb; pc = vpc; imm = vimm;
            in_valid = 1'b1;
            if (push) begin
                e.tk = etk;
                e.tg = etg;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Redirect/flush pattern following a taken accept with FLUSH_CYCLES=2.
    task automatic chk_flush_seq(input string tag);
        @(negedge clk);
        chk({tag, "_redirect1"}, {63'd0, redirect}, 64'd1);
        chk({tag, "_flush1"}, {63'd0, flush}, 64'd1);
        @(negedge clk);
        chk({tag, "_redirect2"}, {63'd0, redirect}, 64'd0);
        chk({tag, "_flush2"}, {63'd0, flush}, 64'd1);
        @(negedge clk);
        chk({tag, "_flush3"}, {63'd0, flush}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op = BR_NOP; a = 32'd0; b = 32'd0; pc = 32'd0; imm = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_taken", {63'd0, taken}, 64'd0);
        chk("rst_target", {32'd0, target}, 64'd0);
        chk("rst_redirect", {63'd0, redirect}, 64'd0);
        chk("rst_flush", {63'd0, flush}, 64'd0);
        chk("rst_br_count", {32'd0, br_count}, 64'd0);
        chk("rst_tk_count", {32'd0, tk_count}, 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // BLT signed: -2^31 < 0 -> taken to pc+4+(0x10<<2)
        issue(BR_BLT, 32'h8000_0000, 32'h0, 32'h0000_1000, 16'h0010, 1'b1, 1'b1, 32'h0000_1044);
        chk_flush_seq("blt");
        // BLTU: 0x80000000 < 0 unsigned is false
        issue(BR_BLTU, 32'h8000_0000, 32'h0, 32'h0000_1000, 16'h0010, 1'b1, 1'b0, 32'h0000_1004);
        @(negedge clk);
        chk("bltu_redirect", {63'd0, redirect}, 64'd0);
        chk("bltu_flush", {63'd0, flush}, 64'd0);
        issue(BR_BGE, 32'h8000_0000, 32'h0, 32'h0000_1000, 16'h0010, 1'b1, 1'b0, 32'h0000_1004);
        issue(BR_BGEU, 32'h8000_0000, 32'h0, 32'h0000_1000, 16'h0010, 1'b1, 1'b1, 32'h0000_1044);

        // BEQ with backward offset lands on itself; the next two beats are squashed.
        issue(BR_BEQ, 32'h8000_0000, 32'h8000_0000, 32'h0000_0100, 16'hFFFF, 1'b1, 1'b1, 32'h0000_0100);
        op = BR_BEQ; a = 32'd7; b = 32'd7; pc = 32'h0000_0300; imm = 16'h0000;
        in_valid = 1'b1;
        @(negedge clk);
        chk("drop_redirect1", {63'd0, redirect}, 64'd1);
        chk("drop_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 a = 32'd9; b = 32'd9;
        @(negedge clk);
        chk("drop_flush2", {63'd0, flush}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        issue(BR_BNE, 32'd5, 32'd5, 32'h0000_0200, 16'h0008, 1'b1, 1'b0, 32'h0000_0204);

        // Assorted direction/target cases
        issue(BR_JR, 32'h0000_4000, 32'h0, 32'h0000_1000, 16'h0010, 1'b1, 1'b1, 32'h0000_4000);
        issue(BR_NOP, 32'h0, 32'h0, 32'h0000_2000, 16'h0010, 1'b1, 1'b0, 32'h0000_2004);
        issue(BR_BEQ, 32'd1, 32'd2, 32'h0000_1000, 16'h0010, 1'b1, 1'b0, 32'h0000_1004);
        issue(BR_BNE, 32'd1, 32'd2, 32'h0000_1000, 16'h0010, 1'b1, 1'b1, 32'h0000_1044);
        issue(BR_BLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1000, 16'h0010, 1'b1, 1'b0, 32'h0000_1004);
        issue(BR_BLTU, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1000, 16'h0010, 1'b1, 1'b1, 32'h0000_1044);
        issue(BR_BEQ, 32'd0, 32'd0, 32'hFFFF_FFF8, 16'h0001, 1'b1, 1'b1, 32'h0000_0000);

        // Output stall: result held, no accept, then release
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(BR_BGE, 32'd0, 32'd1, 32'h0000_0500, 16'h0010, 1'b1, 1'b0, 32'h0000_0504);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_target", {32'd0, target}, {32'd0, 32'h0000_0504});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue(BR_BEQ, 32'd3, 32'd4, 32'h0000_0600, 16'h0010, 1'b1, 1'b0, 32'h0000_0604);

        // Reset in the middle of the squash window discards the pending result
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(BR_JR, 32'h0000_8000, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 32'h0);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_flush", {63'd0, flush}, 64'd0);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_br_count", {32'd0, br_count}, 64'd0);

        // Statistics: 5 branches, 2 taken
        issue(BR_BEQ, 32'd1, 32'd1, 32'h0000_1000, 16'h0004, 1'b1, 1'b1, 32'h0000_1014);
        issue(BR_BNE, 32'd1, 32'd1, 32'h0000_1000, 16'h0004, 1'b1, 1'b0, 32'h0000_1004);
        issue(BR_BLTU, 32'd0, 32'd1, 32'h0000_1000, 16'h0004, 1'b1, 1'b1, 32'h0000_1014);
        issue(BR_BGE, 32'd0, 32'd1, 32'h0000_1000, 16'h0004, 1'b1, 1'b0, 32'h0000_1004);
        issue(BR_BLT, 32'd3, 32'd3, 32'h0000_1000, 16'h0004, 1'b1, 1'b0, 32'h0000_1004);

        begin
            int t;
            t = 0;
            while (q.size() != 0 && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("stats_br_count", {32'd0, br_count}, {32'd0, EXP_BR});
        chk("stats_tk_count", {32'd0, tk_count}, {32'd0, EXP_TK});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
